tl_ul_a_channel_arbiter: RTL and testbench

//  Shares one TileLink-UL master port (A out, D in) between NUM_REQ requesters on the E21 fabric side.

---
 rtl/tl_ul_a_channel_arbiter_if.sv | 45 ++++
 rtl/tl_ul_a_channel_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_tl_ul_a_channel_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tl_ul_a_channel_arbiter_if.sv
// Bundle of the per-requester TileLink-UL ports and the shared downstream
// port. The arbiter connects through the master modport; the requesters
// and the downstream slave connect through the slave modport.
interface tl_ul_a_channel_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned SRCW    = 2,
    parameter int unsigned SZW     = 3
);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW = 74 + SZW + SRCW;
    localparam int unsigned DW = 38 + SZW + SRCW;

    // Requester side
    logic [NUM_REQ-1:0]    req_a_valid;
    logic [NUM_REQ-1:0]    req_a_ready;
    logic [NUM_REQ*AW-1:0] req_a_bits;
    logic [NUM_REQ-1:0]    req_d_valid;
    logic [NUM_REQ-1:0]    req_d_ready;
    logic [DW-1:0]         req_d_bits;

    // Shared downstream port
    logic                  out_a_valid;
    logic                  out_a_ready;
    logic [AW+IW-1:0]      out_a_bits;
    logic                  out_d_valid;
    logic                  out_d_ready;
    logic [DW+IW-1:0]      out_d_bits;

    // D beat that cannot be attributed (unknown source, or no transaction in flight)
    logic                  d_err;

    modport master (
        input  req_a_valid, req_a_bits, req_d_ready,
        input  out_a_ready, out_d_valid, out_d_bits,
        output req_a_ready, req_d_valid, req_d_bits,
        output out_a_valid, out_a_bits, out_d_ready, d_err
    );

    modport slave (
        output req_a_valid, req_a_bits, req_d_ready,
        output out_a_ready, out_d_valid, out_d_bits,
        input  req_a_ready, req_d_valid, req_d_bits,
        input  out_a_valid, out_a_bits, out_d_ready, d_err
    );
endinterface

// File: rtl/tl_ul_a_channel_arbiter.sv
// Round-robin arbiter sharing one TileLink-UL master port among NUM_REQ
// requesters. Multi-beat Puts hold the grant, the requester index is
// prepended to a_source, D beats are routed back by that index, and each
// requester is limited to MAX_OUTST transactions in flight.
// A beat: {opcode[2:0],param[2:0],size,source,address[31:0],mask[3:0],data[31:0]}
// D beat: {opcode[2:0],param[1:0],size,source,denied,data[31:0]}
module tl_ul_a_channel_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned SRCW      = 2,
    parameter int unsigned SZW       = 3,
    parameter int unsigned MAX_OUTST = 4
) (
    input logic                      clock,
    input logic                      reset_n,
    tl_ul_a_channel_arbiter_if.master tl
);
    localparam int unsigned IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW        = 74 + SZW + SRCW;
    localparam int unsigned DW        = 38 + SZW + SRCW;
    localparam int unsigned BCW       = (1 << SZW) - 2;
    localparam int unsigned OW        = $clog2(MAX_OUTST + 1);
    localparam int unsigned A_SRC_LSB = 68;
    localparam int unsigned D_SRC_LSB = 33;
    localparam int unsigned IDX_SPAN  = 1 << IW;
    localparam int unsigned SZ_SPAN   = 1 << SZW;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic {IDLE, BURST} a_state_e;

    a_state_e                     state_q, state_d;
    logic [IW-1:0]                rr_q, rr_d;
    logic [IW-1:0]                lock_q, lock_d;
    logic [BCW-1:0]               a_cnt_q, a_cnt_d;
    logic [BCW-1:0]               d_cnt_q, d_cnt_d;
    logic [NUM_REQ-1:0][OW-1:0]   outst_q, outst_d;

    logic [NUM_REQ-1:0]           full, eligible;
    logic [IW-1:0]                grant, sel;
    logic                         found, a_valid, a_fire, a_first;
    logic [AW-1:0]                sel_bits;
    logic [2:0]                   sel_op;
    logic [SZW-1:0]               sel_size;

    logic [IDX_SPAN-1:0]          idx_map;
    logic [IW-1:0]                d_idx;
    logic                         d_ok, d_fire, d_last, d_uflow;
    logic [2:0]                   d_op;
    logic [SZW-1:0]               d_size;

    // Number of beats minus one for a given size (0 for single-beat sizes)
    function automatic logic [BCW-1:0] beats_m1(input logic [SZW-1:0] sz);
        logic [BCW-1:0] r;
        r = '0;
        for (int unsigned b = 3; b < SZ_SPAN; b++) begin
            if (32'(sz) == b) r = BCW'((1 << (b - 2)) - 1);
        end
        return r;
    endfunction

    // A path: pick the requester (round-robin or locked) and mux it onto the output
    always_comb begin
        int unsigned k;
        k = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            full[i] = (outst_q[i] == OW'(MAX_OUTST));
        end
        eligible = tl.req_a_valid & ~full;
        found    = 1'b0;
        grant    = rr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(rr_q) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && eligible[IW'(k)]) begin
                found = 1'b1;
                grant = IW'(k);
            end
        end
        sel      = (state_q == BURST) ? lock_q : grant;
        sel_bits = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == sel) sel_bits = tl.req_a_bits[i*AW +: AW];
        end
        a_valid = reset_n && ((state_q == BURST) ? tl.req_a_valid[sel] : found);
        tl.out_a_valid = a_valid;
        tl.out_a_bits  = {sel_bits[AW-1:A_SRC_LSB+SRCW], sel, sel_bits[A_SRC_LSB+SRCW-1:0]};
        tl.req_a_ready = '0;
        if (a_valid) tl.req_a_ready[sel] = tl.out_a_ready;
        a_fire   = a_valid && tl.out_a_ready;
        sel_op   = sel_bits[AW-1 -: 3];
        sel_size = sel_bits[A_SRC_LSB+SRCW +: SZW];
    end

    // A FSM next state: lock on the first beat of a multi-beat Put, release on the last
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        a_cnt_d = a_cnt_q;
        rr_d    = rr_q;
        a_first = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    a_first = 1'b1;
                    rr_d    = (32'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
                    if ((sel_op == OP_PUT_FULL || sel_op == OP_PUT_PARTIAL) &&
                        beats_m1(sel_size) != '0) begin
                        state_d = BURST;
                        lock_d  = grant;
                        a_cnt_d = beats_m1(sel_size);
                    end
                end
            end
            BURST: begin
                if (a_fire) begin
                    a_cnt_d = a_cnt_q - 1'b1;
                    if (a_cnt_q == BCW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // D path: route by source MSBs, drop unknown indices, count AccessAckData beats
    always_comb begin
        for (int unsigned i = 0; i < IDX_SPAN; i++) begin
            idx_map[i] = (i < NUM_REQ);
        end
        d_idx  = tl.out_d_bits[D_SRC_LSB+SRCW +: IW];
        d_ok   = idx_map[d_idx];
        d_op   = tl.out_d_bits[DW+IW-1 -: 3];
        d_size = tl.out_d_bits[D_SRC_LSB+SRCW+IW +: SZW];
        tl.req_d_bits  = {tl.out_d_bits[DW+IW-1:D_SRC_LSB+SRCW+IW],
                          tl.out_d_bits[D_SRC_LSB+SRCW-1:0]};
        tl.req_d_valid = '0;
        tl.out_d_ready = 1'b0;
        if (reset_n) begin
            if (d_ok) begin
                tl.req_d_valid[d_idx] = tl.out_d_valid;
                tl.out_d_ready        = tl.req_d_ready[d_idx];
            end else begin
                tl.out_d_ready = 1'b1;
            end
        end
        d_fire  = reset_n && d_ok && tl.out_d_valid && tl.out_d_ready;
        d_cnt_d = d_cnt_q;
        d_last  = 1'b0;
        if (d_fire) begin
            if (d_cnt_q == '0) begin
                if (d_op == OP_ACK_DATA && beats_m1(d_size) != '0) d_cnt_d = beats_m1(d_size);
                else d_last = 1'b1;
            end else begin
                d_cnt_d = d_cnt_q - 1'b1;
                d_last  = (d_cnt_q == BCW'(1));
            end
        end
    end

    // Outstanding counters: a simultaneous issue and retire on one requester cancel out
    always_comb begin
        logic inc, dec;
        inc     = 1'b0;
        dec     = 1'b0;
        outst_d = outst_q;
        d_uflow = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            inc = a_first && (grant == IW'(i));
            dec = d_last && (d_idx == IW'(i));
            if (inc && !dec) begin
                outst_d[i] = outst_q[i] + 1'b1;
            end else if (dec && !inc) begin
                if (outst_q[i] == '0) d_uflow = 1'b1;
                else outst_d[i] = outst_q[i] - 1'b1;
            end
        end
        tl.d_err = reset_n && tl.out_d_valid && (!d_ok || d_uflow);
    end

    // State registers; reset abandons any burst in progress
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
            a_cnt_q <= '0;
            d_cnt_q <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            a_cnt_q <= a_cnt_d;
            d_cnt_q <= d_cnt_d;
            outst_q <= outst_d;
        end
    end
endmodule

// File: tb/tb_tl_ul_a_channel_arbiter.sv
// Directed bench for tl_ul_a_channel_arbiter with NUM_REQ=2, SRCW=2, SZW=3,
// MAX_OUTST=4. Expected beats are assembled field by field from the
// TileLink layouts; all checks sample 1 time unit after the rising edge.
module tb_tl_ul_a_channel_arbiter;
    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;

    localparam logic [2:0] GET = 3'd4;
    localparam logic [2:0] PUTF = 3'd0;
    localparam logic [2:0] ACK = 3'd0;
    localparam logic [2:0] ACKD = 3'd1;

    tl_ul_a_channel_arbiter_if #(.NUM_REQ(2), .SRCW(2), .SZW(3)) bus ();

    tl_ul_a_channel_arbiter #(
        .NUM_REQ(2), .SRCW(2), .SZW(3), .MAX_OUTST(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .tl     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [78:0] mk_a(input logic [2:0] op, input logic [2:0] sz,
                                         input logic [1:0] src, input logic [31:0] addr,
                                         input logic [31:0] data);
        return {op, 3'b000, sz, src, addr, 4'hF, data};
    endfunction

    function automatic logic [79:0] mk_o(input logic [2:0] op, input logic [2:0] sz,
                                         input logic idx, input logic [1:0] src,
                                         input logic [31:0] addr, input logic [31:0] data);
        return {op, 3'b000, sz, idx, src, addr, 4'hF, data};
    endfunction

    function automatic logic [43:0] mk_dout(input logic [2:0] op, input logic [2:0] sz,
                                            input logic idx, input logic [1:0] src,
                                            input logic [31:0] data);
        return {op, 2'b00, sz, idx, src, 1'b0, data};
    endfunction

    function automatic logic [42:0] mk_dreq(input logic [2:0] op, input logic [2:0] sz,
                                            input logic [1:0] src, input logic [31:0] data);
        return {op, 2'b00, sz, src, 1'b0, data};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [1:0] rdy, input logic [79:0] bits);
        chk(tag, 128'({bus.out_a_valid, bus.req_a_ready, bus.out_a_bits}),
                 128'({1'b1, rdy, bits}));
    endtask

    task automatic chk_a_blocked(input string tag);
        chk(tag, 128'({bus.out_a_valid, bus.req_a_ready}), 128'(3'b000));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [78:0] a0_get, a1_get, a0_put, a1_put;
        vectors     = 0;
        miscompares = 0;
        a0_get = mk_a(GET, 3'd2, 2'd1, 32'h0000_1000, 32'h0);
        a1_get = mk_a(GET, 3'd2, 2'd2, 32'h0000_2000, 32'h0);
        a0_put = mk_a(PUTF, 3'd4, 2'd3, 32'h0000_3000, 32'h0000_00AA);
        a1_put = mk_a(PUTF, 3'd4, 2'd0, 32'h0000_4000, 32'h0000_00BB);

        // Reset with both requesters valid
        reset_n         = 1'b0;
        bus.req_a_valid = 2'b11;
        bus.req_a_bits  = {a1_get, a0_get};
        bus.req_d_ready = 2'b11;
        bus.out_a_ready = 1'b1;
        bus.out_d_valid = 1'b0;
        bus.out_d_bits  = '0;
        repeat (3) step();
        chk_a_blocked("reset_a_blocked");
        chk("reset_d", 128'({bus.out_d_ready, bus.req_d_valid}), 128'(3'b000));

        // First cycle after reset: req0 wins, source gets index 0 prepended
        reset_n = 1'b1;
        #1;
        chk_a("first_grant_req0", 2'b01, mk_o(GET, 3'd2, 1'b0, 2'd1, 32'h1000, 32'h0));

        // Back-to-back Gets alternate with no idle cycle
        step();
        chk_a("rr_req1_a", 2'b10, mk_o(GET, 3'd2, 1'b1, 2'd2, 32'h2000, 32'h0));
        step();
        chk_a("rr_req0_b", 2'b01, mk_o(GET, 3'd2, 1'b0, 2'd1, 32'h1000, 32'h0));
        step();
        chk_a("rr_req1_b", 2'b10, mk_o(GET, 3'd2, 1'b1, 2'd2, 32'h2000, 32'h0));

        // req0 PutFull size 4: four locked beats, stall in the middle
        bus.req_a_bits = {a1_get, a0_put};
        step();
        chk_a("put_beat1", 2'b01, mk_o(PUTF, 3'd4, 1'b0, 2'd3, 32'h3000, 32'hAA));
        step();
        chk_a("put_beat2", 2'b01, mk_o(PUTF, 3'd4, 1'b0, 2'd3, 32'h3000, 32'hAA));
        bus.out_a_ready = 1'b0;
        step();
        chk_a("put_stall", 2'b00, mk_o(PUTF, 3'd4, 1'b0, 2'd3, 32'h3000, 32'hAA));
        bus.out_a_ready = 1'b1;
        #1;
        chk_a("put_beat2_resume", 2'b01, mk_o(PUTF, 3'd4, 1'b0, 2'd3, 32'h3000, 32'hAA));
        step();
        chk_a("put_beat3", 2'b01, mk_o(PUTF, 3'd4, 1'b0, 2'd3, 32'h3000, 32'hAA));
        step();
        chk_a("put_beat4", 2'b01, mk_o(PUTF, 3'd4, 1'b0, 2'd3, 32'h3000, 32'hAA));
        step();
        chk_a("after_put_req1", 2'b10, mk_o(GET, 3'd2, 1'b1, 2'd2, 32'h2000, 32'h0));

        // req1 fills to MAX_OUTST (outst0=3, outst1=2 here)
        bus.req_a_valid = 2'b10;
        bus.req_a_bits  = {a1_get, a0_get};
        step();
        chk_a("req1_third", 2'b10, mk_o(GET, 3'd2, 1'b1, 2'd2, 32'h2000, 32'h0));
        step();
        chk_a_blocked("req1_full_blocked");
        bus.req_a_valid = 2'b11;
        #1;
        chk_a("req0_served_while_req1_full", 2'b01, mk_o(GET, 3'd2, 1'b0, 2'd1, 32'h1000, 32'h0));
        step();
        chk_a_blocked("both_full_blocked");

        // One AccessAck to req1 frees a slot
        bus.out_d_valid = 1'b1;
        bus.out_d_bits  = mk_dout(ACK, 3'd2, 1'b1, 2'd2, 32'h0);
        #1;
        chk("ack_route", 128'({bus.req_d_valid, bus.out_d_ready}), 128'(3'b101));
        chk("ack_bits", 128'(bus.req_d_bits), 128'(mk_dreq(ACK, 3'd2, 2'd2, 32'h0)));
        step();
        bus.out_d_valid = 1'b0;
        #1;
        chk_a("req1_after_ack", 2'b10, mk_o(GET, 3'd2, 1'b1, 2'd2, 32'h2000, 32'h0));

        // Refill req1, then a two-beat AccessAckData with backpressure
        step();
        chk_a_blocked("req1_refull");
        bus.out_d_valid = 1'b1;
        bus.out_d_bits  = mk_dout(ACKD, 3'd3, 1'b1, 2'd1, 32'h0000_00D1);
        bus.req_d_ready = 2'b01;
        #1;
        chk("ackd_stall", 128'({bus.req_d_valid, bus.out_d_ready}), 128'(3'b100));
        chk("ackd_bits1", 128'(bus.req_d_bits), 128'(mk_dreq(ACKD, 3'd3, 2'd1, 32'hD1)));
        bus.req_d_ready = 2'b11;
        #1;
        chk("ackd_go", 128'({bus.req_d_valid, bus.out_d_ready}), 128'(3'b101));
        step();
        bus.out_d_bits = mk_dout(ACKD, 3'd3, 1'b1, 2'd1, 32'h0000_00D2);
        #1;
        chk_a_blocked("ackd_beat1_no_release");
        chk("ackd_bits2", 128'(bus.req_d_bits), 128'(mk_dreq(ACKD, 3'd3, 2'd1, 32'hD2)));
        step();
        bus.out_d_valid = 1'b0;
        #1;
        chk_a("req1_after_ackd", 2'b10, mk_o(GET, 3'd2, 1'b1, 2'd2, 32'h2000, 32'h0));
        chk("d_quiet", 128'(bus.req_d_valid), 128'(2'b00));

        // req1 PutFull, reset during beat 2
        bus.req_a_bits = {a1_put, a0_get};
        #1;
        chk_a("req1_put_beat1", 2'b10, mk_o(PUTF, 3'd4, 1'b1, 2'd0, 32'h4000, 32'hBB));
        step();
        chk_a("req1_put_beat2", 2'b10, mk_o(PUTF, 3'd4, 1'b1, 2'd0, 32'h4000, 32'hBB));
        reset_n = 1'b0;
        #1;
        chk_a_blocked("midburst_reset_a");
        chk("midburst_reset_d", 128'({bus.out_d_ready, bus.req_d_valid}), 128'(3'b000));
        repeat (2) step();
        reset_n = 1'b1;
        #1;
        chk_a("restart_req0", 2'b01, mk_o(GET, 3'd2, 1'b0, 2'd1, 32'h1000, 32'h0));
        step();
        chk_a("restart_req1_put", 2'b10, mk_o(PUTF, 3'd4, 1'b1, 2'd0, 32'h4000, 32'hBB));
        step();
        chk_a("restart_req1_locked", 2'b10, mk_o(PUTF, 3'd4, 1'b1, 2'd0, 32'h4000, 32'hBB));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
